// File: rtl/pc_fetch_unit.sv
// Program counter / next-PC stage with supervisor bit, interrupt and illegal-op entry.
// Entry requests the $xp return-address write combinationally in the entry cycle.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] INT_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] jr_target,
  input  logic        irq,
  input  logic        illop,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        int_taken,
  output logic        exc_taken,
  output logic        xp_we,
  output logic [31:0] xp_data
);

  localparam logic [1:0] SRC_SEQ = 2'd0;
  localparam logic [1:0] SRC_BR  = 2'd1;
  localparam logic [1:0] SRC_J   = 2'd2;
  localparam logic [1:0] SRC_JR  = 2'd3;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  sync_q;
  logic        irq_prev_q;
  logic        pend_q, pend_d;

  logic        irq_s, irq_rise;
  logic [30:0] p4_lo, br_lo;
  logic [31:0] p4, next_pc;
  logic        exc_go, int_go;

  assign irq_s    = sync_q[1];
  assign irq_rise = irq_s & ~irq_prev_q;

  // Arithmetic is done on bits 30:0 only so the supervisor bit never carries.
  assign p4_lo = pc_q[30:0] + 31'd4;
  assign p4    = {pc_q[31], p4_lo};
  assign br_lo = p4[30:0] + {{13{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    next_pc = p4;
    case (pc_src)
      SRC_SEQ: next_pc = p4;
      SRC_BR:  next_pc = branch_taken ? {pc_q[31], br_lo} : p4;
      SRC_J:   next_pc = {pc_q[31], p4[30:28], target26, 2'b00};
      SRC_JR:  next_pc = {pc_q[31] & jr_target[31], jr_target[30:0]};
      default: next_pc = p4;
    endcase
  end

  // Interrupts are masked in kernel mode and lose to an illegal op.
  assign exc_go = ~stall & illop;
  assign int_go = ~stall & pend_q & ~pc_q[31] & ~illop;

  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q | irq_rise;
    if (!stall) begin
      if (exc_go)      pc_d = EXC_VEC;
      else if (int_go) begin
        pc_d   = INT_VEC;
        pend_d = irq_rise;
      end
      else             pc_d = next_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_VEC;
      sync_q     <= 2'b00;
      irq_prev_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      sync_q     <= {sync_q[0], irq};
      irq_prev_q <= irq_s;
      pend_q     <= pend_d;
    end
  end

  assign pc        = pc_q;
  assign pc_plus4  = p4;
  assign exc_taken = exc_go;
  assign int_taken = int_go;
  assign xp_we     = exc_go | int_go;
  assign xp_data   = exc_go ? p4 : (int_go ? pc_q : 32'd0);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench for pc_fetch_unit: a cycle-indexed reference model pushes the
// expected outputs of each cycle, a negedge monitor pops and compares them.
module tb_pc_fetch_unit;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] IV = 32'h8000_0004;
  localparam logic [31:0] EV = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken, irq, illop;
  logic [1:0]  pc_src;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] jr_target;
  logic [31:0] pc, pc_plus4, xp_data;
  logic        int_taken, exc_taken, xp_we;

  pc_fetch_unit #(.RESET_VEC(RV), .INT_VEC(IV), .EXC_VEC(EV)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_src(pc_src),
    .branch_taken(branch_taken), .imm16(imm16), .target26(target26),
    .jr_target(jr_target), .irq(irq), .illop(illop), .pc(pc),
    .pc_plus4(pc_plus4), .int_taken(int_taken), .exc_taken(exc_taken),
    .xp_we(xp_we), .xp_data(xp_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, p4;
    logic        it, et, we;
    logic [31:0] xd;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: PC, pending flag and the irq level applied in each cycle since reset.
  logic [31:0] m_pc;
  logic        m_pend;
  logic        irqh[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic hist(input int k);
    if (k < 0 || k >= irqh.size()) return 1'b0;
    return irqh[k];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.p4);
      chk("int_taken", {31'd0, int_taken}, {31'd0, e.it});
      chk("exc_taken", {31'd0, exc_taken}, {31'd0, e.et});
      chk("xp_we", {31'd0, xp_we}, {31'd0, e.we});
      chk("xp_data", xp_data, e.xd);
    end
  end

  // One cycle: called at a negedge, drives inputs, predicts outputs, advances the model.
  task automatic cyc(input logic st, input logic [1:0] src, input logic bt,
                     input logic [15:0] im, input logic [25:0] t26,
                     input logic [31:0] jr, input logic iq, input logic il);
    exp_t e;
    logic [31:0] p4, nx, sx;
    logic rise;
    int n;
    stall = st; pc_src = src; branch_taken = bt; imm16 = im;
    target26 = t26; jr_target = jr; irq = iq; illop = il;
    n = irqh.size();
    irqh.push_back(iq);
    p4 = ((m_pc + 32'd4) & 32'h7FFF_FFFF) | (m_pc & 32'h8000_0000);
    sx = {{16{im[15]}}, im} << 2;
    case (src)
      2'd1:    nx = bt ? (((p4 + sx) & 32'h7FFF_FFFF) | (m_pc & 32'h8000_0000)) : p4;
      2'd2:    nx = (m_pc & 32'h8000_0000) | (p4 & 32'h7000_0000) | ({6'd0, t26} << 2);
      2'd3:    nx = (jr & 32'h7FFF_FFFF) | (jr & m_pc & 32'h8000_0000);
      default: nx = p4;
    endcase
    e.pc = m_pc; e.p4 = p4;
    e.et = !st && il;
    e.it = !st && m_pend && !m_pc[31] && !il;
    e.we = e.et || e.it;
    e.xd = e.et ? p4 : (e.it ? m_pc : 32'd0);
    sbq.push_back(e);
    // irq reaches the edge detector two clocks after it is applied
    rise = hist(n - 2) && !hist(n - 3);
    if (!st) m_pc = e.et ? EV : (e.it ? IV : nx);
    m_pend = e.it ? rise : (m_pend || rise);
    @(negedge clk);
  endtask

  task automatic seq(input int k, input logic iq);
    for (int i = 0; i < k; i++) cyc(1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, iq, 1'b0);
  endtask

  task automatic jr_to(input logic [31:0] a);
    cyc(1'b0, 2'd3, 1'b0, 16'd0, 26'd0, a, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 0; pc_src = 0; branch_taken = 0; imm16 = 0; target26 = 0;
    jr_target = 0; irq = 0; illop = 0;
    #1;
    chk("rst_pc", pc, RV);
    chk("rst_pc_plus4", pc_plus4, RV + 32'd4);
    chk("rst_xp_we", {31'd0, xp_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_pc = RV; m_pend = 1'b0; irqh.delete();
  endtask

  initial begin
    logic [31:0] jr;
    logic iq;
    @(negedge clk);
    do_reset();

    // sequential, then asynchronous reset in the middle of the pc=C cycle
    seq(3, 1'b0);
    chk("pc_before_async_rst", pc, 32'h0000_000C);
    #2 reset = 1'b1;
    #1 chk("async_rst_pc", pc, RV);
    @(negedge clk);
    do_reset();

    // branch taken back one word, then not taken
    jr_to(32'h18);
    cyc(1'b0, 2'd1, 1'b1, 16'hFFFE, 26'd0, 32'd0, 1'b0, 1'b0);
    jr_to(32'h18);
    cyc(1'b0, 2'd1, 1'b0, 16'hFFFE, 26'd0, 32'd0, 1'b0, 1'b0);
    // jump, keep user mode
    cyc(1'b0, 2'd2, 1'b0, 16'd0, 26'h3FF_FFFF, 32'd0, 1'b0, 1'b0);

    // kernel entry via illop, kernel jr to user, user jr cannot set bit31
    cyc(1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1);
    jr_to(32'h8000_0208);
    jr_to(32'h0000_0044);
    jr_to(32'h0000_0040);
    jr_to(32'h8000_00CC);
    // supervisor bit does not carry out of pc+4 wrap
    jr_to(32'h7FFF_FFFC);
    seq(1, 1'b0);

    // interrupt in user; second irq in kernel stays pending until return
    jr_to(32'h34);
    seq(1, 1'b1);
    seq(4, 1'b0);
    seq(1, 1'b1);
    seq(5, 1'b0);
    jr_to(32'h100);
    seq(2, 1'b0);

    // illop beats pending interrupt; pending survives
    seq(1, 1'b1);
    seq(4, 1'b0);
    jr_to(32'h60);
    cyc(1'b0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0, 1'b1);
    seq(2, 1'b0);
    jr_to(32'h200);
    seq(2, 1'b0);

    // stall with irq edge: hold, then take on first unstalled user cycle
    jr_to(32'h300);
    cyc(1'b1, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd1, 1'b1, 16'h0010, 26'd0, 32'd0, 1'b0, 1'b1);
    seq(3, 1'b0);

    // randomized traffic
    iq = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) iq = ~iq;
      jr = $urandom;
      if ($urandom_range(1) == 0) jr[31] = 1'b0;
      cyc($urandom_range(7) == 0, 2'($urandom_range(3)), 1'($urandom),
          16'($urandom), 26'($urandom), jr, iq, $urandom_range(15) == 0);
      if (i == 1500) begin
        @(negedge clk);
        do_reset();
      end
    end

    @(negedge clk);
    #5;
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
